// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester register-file writeback arbiter
//
// Purpose: merges ALU (requester 0) and load (requester 1) writebacks onto a
// single registered register-file write port. Ready is combinational, so a
// lone requester is accepted in the cycle it presents. The write appears on
// the RF port one cycle after acceptance.
//
// Configuration macro: RF_WB_RR_ARB_EN
//   defined   - contention resolved round-robin against last_gnt
//   undefined - requester 0 always wins contention
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   req0_valid_i/dst_i/data_i        requester 0 write request
//   req0_ready_o                     grant to requester 0
//   req1_valid_i/dst_i/data_i        requester 1 write request
//   req1_ready_o                     grant to requester 1
//   hold_i                           blocks all grants while high
//   rf_we_o, rf_dst_o, rf_data_o     registered register-file write port
//   conflict_cnt_o                   saturating count of contention cycles
module rf_wb_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int ZERO_WR_BLOCK = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_dst_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_dst_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    input  logic              hold_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_dst_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic [15:0]       conflict_cnt_o
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Index of the most recently granted requester; resets to 1 so that
    // round-robin hands the first contention to requester 0.
    logic              last_gnt;
    logic              both_valid;
    logic              xfer0;
    logic              xfer1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_dst;
    logic [DATA_W-1:0] sel_data;
    logic              zero_blk;

    assign both_valid = req0_valid_i & req1_valid_i;

    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if (!rst_i && !hold_i) begin
            if (both_valid) begin
`ifdef RF_WB_RR_ARB_EN
                if (last_gnt == 1'b0) begin
                    req1_ready_o = 1'b1;
                end else begin
                    req0_ready_o = 1'b1;
                end
`else
                req0_ready_o = 1'b1;
`endif
            end else if (req0_valid_i) begin
                req0_ready_o = 1'b1;
            end else if (req1_valid_i) begin
                req1_ready_o = 1'b1;
            end
        end
    end

    assign xfer0    = req0_valid_i & req0_ready_o;
    assign xfer1    = req1_valid_i & req1_ready_o;
    assign xfer     = xfer0 | xfer1;
    assign sel_dst  = xfer1 ? req1_dst_i  : req0_dst_i;
    assign sel_data = xfer1 ? req1_data_i : req0_data_i;

    // Register 0 is hardwired zero in the RF: accept the handshake so the
    // producer retires, but never raise the write enable for it.
    assign zero_blk = (ZERO_WR_BLOCK != 0) && (sel_dst == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o        <= 1'b0;
            rf_dst_o       <= '0;
            rf_data_o      <= '0;
            conflict_cnt_o <= '0;
            last_gnt       <= 1'b1;
        end else begin
            rf_we_o <= xfer && !zero_blk;
            if (xfer) begin
                rf_dst_o  <= sel_dst;
                rf_data_o <= sel_data;
                last_gnt  <= xfer1;
            end
            // Contention is counted on both valids, even while held.
            if (both_valid && (conflict_cnt_o != CNT_MAX)) begin
                conflict_cnt_o <= conflict_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

`ifdef RF_WB_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_dst;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_dst;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        hold;
    logic        rf_we;
    logic [4:0]  rf_dst;
    logic [31:0] rf_data;
    logic [15:0] conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic g1;

    rf_wb_arbiter #(
        .DATA_W        (32),
        .ADDR_W        (5),
        .ZERO_WR_BLOCK (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req0_valid_i   (req0_valid),
        .req0_dst_i     (req0_dst),
        .req0_data_i    (req0_data),
        .req0_ready_o   (req0_ready),
        .req1_valid_i   (req1_valid),
        .req1_dst_i     (req1_dst),
        .req1_data_i    (req1_data),
        .req1_ready_o   (req1_ready),
        .hold_i         (hold),
        .rf_we_o        (rf_we),
        .rf_dst_o       (rf_dst),
        .rf_data_o      (rf_data),
        .conflict_cnt_o (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with req0 already presenting dst=3.
        rst = 1'b1; hold = 1'b0;
        req0_valid = 1'b1; req0_dst = 5'd3; req0_data = 32'hDEAD_BEEF;
        req1_valid = 1'b0; req1_dst = 5'd0; req1_data = 32'h0;
        #1;
        chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("rst_we",   {31'b0, rf_we}, 32'd0);
        chk("rst_dst",  {27'b0, rf_dst}, 32'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_cnt",  {16'b0, conflict_cnt}, 32'd0);

        // Pending request granted in the first cycle out of reset.
        rst = 1'b0;
        #1;
        chk("first_ready0", {31'b0, req0_ready}, 32'd1);
        chk("first_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("first_we",   {31'b0, rf_we}, 32'd1);
        chk("first_dst",  {27'b0, rf_dst}, 32'd3);
        chk("first_data", rf_data, 32'hDEAD_BEEF);
        req0_valid = 1'b0;
        tick();
        chk("idle_we",   {31'b0, rf_we}, 32'd0);
        chk("idle_dst",  {27'b0, rf_dst}, 32'd3);
        chk("idle_data", rf_data, 32'hDEAD_BEEF);

        // Contention for 4 cycles from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_dst = 5'd1; req0_data = 32'hA1;
        req1_valid = 1'b1; req1_dst = 5'd2; req1_data = 32'hA2;
        for (int i = 0; i < 4; i++) begin
            g1 = RR ? i[0] : 1'b0;
            #1;
            chk("cont_ready0", {31'b0, req0_ready}, {31'b0, ~g1});
            chk("cont_ready1", {31'b0, req1_ready}, {31'b0, g1});
            tick();
            chk("cont_we",   {31'b0, rf_we}, 32'd1);
            chk("cont_dst",  {27'b0, rf_dst}, g1 ? 32'd2 : 32'd1);
            chk("cont_data", rf_data, g1 ? 32'hA2 : 32'hA1);
        end
        chk("cont_cnt", {16'b0, conflict_cnt}, 32'd4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("cont_after_we",  {31'b0, rf_we}, 32'd0);
        chk("cont_after_cnt", {16'b0, conflict_cnt}, 32'd4);

        // Hold with both valid for 2 cycles, then release.
        rst = 1'b1;
        tick();
        rst = 1'b0; hold = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_ready0", {31'b0, req0_ready}, 32'd0);
            chk("hold_ready1", {31'b0, req1_ready}, 32'd0);
            tick();
            chk("hold_we", {31'b0, rf_we}, 32'd0);
        end
        chk("hold_cnt", {16'b0, conflict_cnt}, 32'd2);
        hold = 1'b0;
        #1;
        chk("unhold_ready0", {31'b0, req0_ready}, 32'd1);
        chk("unhold_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("unhold_we",  {31'b0, rf_we}, 32'd1);
        chk("unhold_dst", {27'b0, rf_dst}, 32'd1);
        chk("unhold_cnt", {16'b0, conflict_cnt}, 32'd3);

        // Reset right after a transfer drops the visible write.
        req1_valid = 1'b0;
        req0_dst = 5'd7; req0_data = 32'h77;
        tick();
        chk("pre_rst_we",  {31'b0, rf_we}, 32'd1);
        chk("pre_rst_dst", {27'b0, rf_dst}, 32'd7);
        rst = 1'b1; req0_valid = 1'b0;
        tick();
        chk("drop_we",   {31'b0, rf_we}, 32'd0);
        chk("drop_cnt",  {16'b0, conflict_cnt}, 32'd0);
        chk("drop_dst",  {27'b0, rf_dst}, 32'd0);
        chk("drop_data", rf_data, 32'd0);

        // Write to register 0 completes handshake with no write enable.
        rst = 1'b0;
        req1_valid = 1'b1; req1_dst = 5'd0; req1_data = 32'h1;
        #1;
        chk("zero_ready1", {31'b0, req1_ready}, 32'd1);
        chk("zero_ready0", {31'b0, req0_ready}, 32'd0);
        tick();
        chk("zero_we", {31'b0, rf_we}, 32'd0);

        // Lone req1 write to a nonzero register.
        req1_dst = 5'd9; req1_data = 32'h99;
        tick();
        chk("req1_we",   {31'b0, rf_we}, 32'd1);
        chk("req1_dst",  {27'b0, rf_dst}, 32'd9);
        chk("req1_data", rf_data, 32'h99);
        req1_valid = 1'b0;

        // Counter saturation: contention held for 65536 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0; hold = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_minus1", {16'b0, conflict_cnt}, 32'h0000_FFFE);
        tick();
        chk("sat_max", {16'b0, conflict_cnt}, 32'h0000_FFFF);
        tick();
        chk("sat_hold", {16'b0, conflict_cnt}, 32'h0000_FFFF);
        hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the write-data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the destination-register index width.
REQ-003 Parameter ZERO_WR_BLOCK, default 1, SHALL suppress register-0 writes when 1 (see REQ-014).
REQ-004 clk_i  in  1  SHALL be the single clock; all state updates on posedge clk_i.
REQ-005 rst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-006 req0_valid_i  in  1  SHALL mean requester 0 (ALU writeback) has a write pending.
REQ-007 req0_dst_i  in  ADDR_W  SHALL carry the destination index for requester 0.
REQ-008 req0_data_i  in  DATA_W  SHALL carry the write data for requester 0.
REQ-009 req0_ready_o  out  1  SHALL be the grant to requester 0; transfer occurs on valid && ready.
REQ-010 req1_valid_i, req1_dst_i, req1_data_i, req1_ready_o SHALL have the same widths and meaning for requester 1 (memory/load writeback).
REQ-011 hold_i  in  1  SHALL block all grants while high.
REQ-012 rf_we_o  out  1, rf_dst_o  out  ADDR_W, rf_data_o  out  DATA_W  SHALL drive the register-file write port; all three are registered.
REQ-013 conflict_cnt_o  out  16  SHALL report the saturating count of contention cycles.

Function
REQ-014 When ZERO_WR_BLOCK=1, a transfer with dst==0 SHALL complete the handshake but SHALL produce rf_we_o=0 on the following cycle.
REQ-015 A grant SHALL be issued only when hold_i=0 and at least one valid is high; at most one ready SHALL be high per cycle.
REQ-016 If exactly one requester is valid and hold_i=0, that requester SHALL be granted in the same cycle (combinational ready).
REQ-017 If both requesters are valid, the winner SHALL be selected per REQ-028/REQ-029.
REQ-018 A transfer in cycle N SHALL appear on rf_we_o/rf_dst_o/rf_data_o in cycle N+1 (latency 1), held for exactly one cycle.
REQ-019 In any cycle with no transfer, rf_we_o SHALL be 0 in the next cycle; rf_dst_o/rf_data_o SHALL hold their last values.
REQ-020 Requesters SHALL hold valid, dst and data stable until ready; the block SHALL NOT latch unaccepted requests.
REQ-021 State last_gnt (1 bit) SHALL update to the granted requester index only on a transfer; it SHALL be unchanged when there is no transfer or hold_i=1.
REQ-022 A contention cycle is one in which both valids are high (regardless of hold_i); conflict_cnt_o SHALL increment by 1 per such cycle and saturate at 16'hFFFF.
REQ-023 Both requesters targeting the same dst SHALL be serialized in grant order; the later grant's data SHALL be the final RF content.
REQ-024 Sustained back-to-back transfers SHALL be supported, one per cycle, with no bubble.

Reset
REQ-025 While rst_i=1 at posedge, the block SHALL set rf_we_o=0, rf_dst_o=0, rf_data_o=0, conflict_cnt_o=0 and last_gnt=1.
REQ-026 While rst_i=1, both ready outputs SHALL be 0; no transfer SHALL occur.
REQ-027 A request valid during the reset cycle SHALL be granted in the first cycle after rst_i deasserts, if still valid.

Configuration
REQ-028 With macro RF_WB_RR_ARB_EN defined, contention SHALL be resolved round-robin: grant the requester != last_gnt (requester 0 wins the first contention after reset).
REQ-029 Without RF_WB_RR_ARB_EN, contention SHALL be resolved by fixed priority: requester 0 always wins; last_gnt SHALL still be maintained.

Verification
REQ-030 Reset, then req0 valid dst=3 data=32'hDEAD_BEEF -> req0_ready_o=1 same cycle; next cycle rf_we_o=1, rf_dst_o=3, rf_data_o=32'hDEAD_BEEF.
REQ-031 RR_EN defined, both valid for 4 cycles (dst 1 and 2) -> grants 0,1,0,1; rf_dst_o sequence 1,2,1,2; conflict_cnt_o=4.
REQ-032 RR_EN undefined, both valid for 3 cycles -> req0 granted all 3 cycles, req1_ready_o=0 throughout, conflict_cnt_o=3.
REQ-033 hold_i=1 with both valid for 2 cycles, then hold_i=0 -> no ready and rf_we_o=0 during hold; conflict_cnt_o=2; first grant afterwards to requester 0 after reset.
REQ-034 ZERO_WR_BLOCK=1, req1 valid dst=0 data=32'h1 -> req1_ready_o=1; next cycle rf_we_o=0.
REQ-035 Assert rst_i in the cycle after a transfer -> rf_we_o=0, conflict_cnt_o=0 on the next posedge; the pending write is dropped.
